datapath_pipe: RTL

DATAPATH_PIPE -- requirements
Module: datapath_pipe

---
 rtl/datapath_pipe.sv | 105 ++++++++++
 1 files changed

// File: rtl/datapath_pipe.sv
// datapath_pipe: two-stage issue/execute pipeline around an NREG x DW register file.
// Define DATAPATH_PIPE_FWD_EN to forward the pending S2 write to the read ports.
module datapath_pipe #(
    parameter int DW   = 16,
    parameter int NREG = 16,
    localparam int AW  = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [AW-1:0] Rp_addr,
    input  logic [AW-1:0] Rq_addr,
    input  logic          Rp_rd,
    input  logic          Rq_rd,
    input  logic [AW-1:0] W_addr,
    input  logic          W_wr,
    input  logic [1:0]    wb_sel,
    input  logic [2:0]    alu_op,
    input  logic [DW-1:0] imm,
    input  logic [DW-1:0] DM_Din,
    output logic [DW-1:0] Rp_data,
    output logic          Rp_zero,
    output logic          wb_valid,
    output logic [AW-1:0] wb_addr,
    output logic [DW-1:0] wb_data,
    output logic [2:0]    flags
);
    logic [DW-1:0] regs [NREG];
    logic          ex_valid, ex_wr;
    logic [2:0]    ex_op;
    logic [1:0]    ex_sel;
    logic [AW-1:0] ex_addr;
    logic [DW-1:0] ex_a, ex_b, ex_imm, ex_din;
    logic [DW:0]   alu;
    logic [DW-1:0] s2_data, p_raw, q_raw, q_data;
    logic          s2_we;

    // alu[DW] is the carry/borrow/shifted-out bit for every op
    always_comb begin
        alu = '0;
        case (ex_op)
            3'd0: alu = {1'b0, ex_a};
            3'd1: alu = {1'b0, ex_a} + {1'b0, ex_b};
            3'd2: alu = {1'b0, ex_a} - {1'b0, ex_b};
            3'd3: alu = {1'b0, ex_a & ex_b};
            3'd4: alu = {1'b0, ex_a | ex_b};
            3'd5: alu = {1'b0, ex_a ^ ex_b};
            3'd6: alu = {ex_a, 1'b0};
            default: alu = {ex_a[0], 1'b0, ex_a[DW-1:1]};
        endcase
    end

    assign s2_we   = ex_valid & ex_wr & (ex_sel != 2'b11);
    assign s2_data = (ex_sel == 2'b00) ? alu[DW-1:0] : (ex_sel == 2'b01) ? ex_din : ex_imm;

`ifdef DATAPATH_PIPE_FWD_EN
    assign p_raw = (s2_we && Rp_addr == ex_addr) ? s2_data : regs[Rp_addr];
    assign q_raw = (s2_we && Rq_addr == ex_addr) ? s2_data : regs[Rq_addr];
`else
    assign p_raw = regs[Rp_addr];
    assign q_raw = regs[Rq_addr];
`endif

    assign Rp_data = Rp_rd ? p_raw : '0;
    assign q_data  = Rq_rd ? q_raw : '0;
    assign Rp_zero = (Rp_data == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            ex_valid <= 1'b0;
            ex_wr    <= 1'b0;
            ex_op    <= '0;
            ex_sel   <= '0;
            ex_addr  <= '0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_imm   <= '0;
            ex_din   <= '0;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            flags    <= '0;
        end else begin
            ex_valid <= in_valid;
            if (in_valid) begin
                ex_a    <= Rp_data;
                ex_b    <= q_data;
                ex_op   <= alu_op;
                ex_sel  <= wb_sel;
                ex_imm  <= imm;
                ex_din  <= DM_Din;
                ex_addr <= W_addr;
                ex_wr   <= W_wr;
            end
            wb_valid <= s2_we;
            if (s2_we) begin
                regs[ex_addr] <= s2_data;
                wb_addr       <= ex_addr;
                wb_data       <= s2_data;
                if (ex_sel == 2'b00) flags <= {alu[DW-1], alu[DW], alu[DW-1:0] == '0};
            end
        end
    end
endmodule
